// File: rtl/switch_press_decoder_pkg.sv
// Shared definitions for the switch press decoder.
// Holds the event_type encodings, the press state enumeration and the
// event queue depth used by the decoder and its event FIFO.
package switch_press_decoder_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_SHORT  = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_REPEAT = 2'b11
  } evt_type_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_HELD    = 2'b10
  } press_state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/switch_event_fifo.sv
// Two-entry event queue for the switch press decoder.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   push, push_data     enqueue request and 2-bit event code
//   pop                 dequeue request (ignored while empty)
//   head_data           oldest entry, 00 while empty
//   full, empty         occupancy flags
// A push while full is taken only when a pop happens on the same edge.
module switch_event_fifo
  import switch_press_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop,
  output logic [1:0] head_data,
  output logic       full,
  output logic       empty
);

  logic [1:0] entry0;
  logic [1:0] entry1;
  logic [1:0] level;
  logic       pop_ok;
  logic       push_ok;

  assign full      = (level == 2'(FIFO_DEPTH));
  assign empty     = (level == 2'd0);
  assign head_data = empty ? 2'b00 : entry0;

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // entry0 is always the head; a pop shifts entry1 forward.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry0 <= 2'b00;
      entry1 <= 2'b00;
      level  <= 2'd0;
    end else begin
      if (pop_ok) begin
        if (level == 2'd2) begin
          entry0 <= entry1;
          if (push_ok) entry1 <= push_data;
        end else if (push_ok) begin
          entry0 <= push_data;
        end
      end else if (push_ok) begin
        if (level == 2'd0) entry0 <= push_data;
        else               entry1 <= push_data;
      end

      if (push_ok && !pop_ok)      level <= level + 2'd1;
      else if (!push_ok && pop_ok) level <= level - 2'd1;
    end
  end

endmodule

// File: rtl/switch_press_decoder.sv
// Switch press decoder: turns a debounced switch level into SHORT, LONG
// and REPEAT events, sampled on clk_enable ticks, and queues them in a
// two-entry FIFO for a consumer.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   clk_enable            tick qualifier for the press state machine
//   switch_level          debounced level, 1 = pressed
//   long_press_ticks      high ticks for a long press (<2 disables)
//   repeat_ticks          ticks between repeats while held (0 disables)
//   event_ack             consumer accepts the head event
//   overflow_clear        clears event_overflow
//   event_valid           queue not empty
//   event_type            head event: 01 SHORT, 10 LONG, 11 REPEAT
//   event_overflow        sticky, an event was dropped
//   pressed               state machine is not IDLE
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_IDLE    | switch released, waiting for a high tick
// ST_PRESSED | switch high, counting towards a long press
// ST_HELD    | long press reported, counting towards repeats
module switch_press_decoder
  import switch_press_decoder_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_enable,
  input  logic                   switch_level,
  input  logic [COUNT_WIDTH-1:0] long_press_ticks,
  input  logic [COUNT_WIDTH-1:0] repeat_ticks,
  input  logic                   event_ack,
  input  logic                   overflow_clear,
  output logic                   event_valid,
  output logic [1:0]             event_type,
  output logic                   event_overflow,
  output logic                   pressed
);

  press_state_t           state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   count_sat;
  logic                   long_en;
  logic                   push;
  evt_type_t              push_type;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   drop;

  assign count_sat = &count_q;
  assign count_inc = count_sat ? count_q : count_q + COUNT_WIDTH'(1);
  assign long_en   = (long_press_ticks >= COUNT_WIDTH'(2));

  // Compares are gated by !count_sat so a saturated count that happens to
  // equal the threshold does not fire on every tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    push      = 1'b0;
    push_type = EVT_NONE;
    if (clk_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (switch_level) begin
            state_d = ST_PRESSED;
            count_d = COUNT_WIDTH'(1);
          end
        end
        ST_PRESSED: begin
          if (!switch_level) begin
            push      = 1'b1;
            push_type = EVT_SHORT;
            state_d   = ST_IDLE;
          end else begin
            count_d = count_inc;
            if (long_en && !count_sat && (count_inc == long_press_ticks)) begin
              push      = 1'b1;
              push_type = EVT_LONG;
              state_d   = ST_HELD;
              count_d   = '0;
            end
          end
        end
        ST_HELD: begin
          if (!switch_level) begin
            state_d = ST_IDLE;
          end else if (repeat_ticks != '0) begin
            count_d = count_inc;
            if (!count_sat && (count_inc == repeat_ticks)) begin
              push      = 1'b1;
              push_type = EVT_REPEAT;
              count_d   = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign event_valid = ~fifo_empty;
  assign pop         = event_valid & event_ack;
  assign drop        = push & fifo_full & ~pop;
  assign pressed     = (state_q != ST_IDLE);

  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            event_overflow <= 1'b0;
    else if (drop)           event_overflow <= 1'b1;
    else if (overflow_clear) event_overflow <= 1'b0;
  end

  switch_event_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_type),
    .pop       (pop),
    .head_data (event_type),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_switch_press_decoder.sv
// Directed testbench for switch_press_decoder.
module tb_switch_press_decoder;

  logic        clk;
  logic        reset_n;
  logic        clk_enable;
  logic        switch_level;
  logic [15:0] long_press_ticks;
  logic [15:0] repeat_ticks;
  logic        event_ack;
  logic        overflow_clear;
  logic        event_valid;
  logic [1:0]  event_type;
  logic        event_overflow;
  logic        pressed;

  int checks;
  int failures;

  switch_press_decoder #(.COUNT_WIDTH(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .clk_enable       (clk_enable),
    .switch_level     (switch_level),
    .long_press_ticks (long_press_ticks),
    .repeat_ticks     (repeat_ticks),
    .event_ack        (event_ack),
    .overflow_clear   (overflow_clear),
    .event_valid      (event_valid),
    .event_type       (event_type),
    .event_overflow   (event_overflow),
    .pressed          (pressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({event_valid, event_type, event_overflow, pressed} !== 5'b0_00_0_0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b t=%b ovf=%b p=%b want all 0",
               event_valid, event_type, event_overflow, pressed);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if ({event_valid, pressed} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle: got v=%b p=%b want 0 0", event_valid, pressed);
    end
  endtask

  task automatic test_short();
    clk_enable = 1'b1; long_press_ticks = 16'd10; repeat_ticks = 16'd0;
    event_ack = 1'b1; switch_level = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if ({pressed, event_valid} !== 2'b10) begin
        failures++;
        $display("FAIL short_hold tick %0d: got p=%b v=%b want p=1 v=0", i, pressed, event_valid);
      end
    end
    switch_level = 1'b0;
    step();
    checks++;
    if ({pressed, event_valid, event_type} !== 4'b0_1_01) begin
      failures++;
      $display("FAIL short_event: got p=%b v=%b t=%b want p=0 v=1 t=01",
               pressed, event_valid, event_type);
    end
    step();
    checks++;
    if (event_valid !== 1'b0) begin
      failures++;
      $display("FAIL short_popped: got v=%b want 0", event_valid);
    end
  endtask

  task automatic test_long_repeat();
    logic       exp_v;
    logic [1:0] exp_t;
    clk_enable = 1'b1; long_press_ticks = 16'd10; repeat_ticks = 16'd4;
    event_ack = 1'b1; switch_level = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      step();
      exp_v = (i == 10) || (i == 14) || (i == 18) || (i == 22);
      exp_t = (i == 10) ? 2'b10 : (exp_v ? 2'b11 : 2'b00);
      checks++;
      if ({event_valid, event_type} !== {exp_v, exp_t}) begin
        failures++;
        $display("FAIL long_repeat tick %0d: got v=%b t=%b want v=%b t=%b",
                 i, event_valid, event_type, exp_v, exp_t);
      end
    end
    switch_level = 1'b0;
    step();
    step();
    checks++;
    if ({event_valid, pressed} !== 2'b00) begin
      failures++;
      $display("FAIL long_release: got v=%b p=%b want 0 0", event_valid, pressed);
    end
  endtask

  task automatic test_mid_change();
    clk_enable = 1'b1; long_press_ticks = 16'd10; repeat_ticks = 16'd0;
    event_ack = 1'b1; switch_level = 1'b1;
    repeat (3) step();
    long_press_ticks = 16'd5;
    step();
    checks++;
    if (event_valid !== 1'b0) begin
      failures++;
      $display("FAIL grow_early: got v=%b want 0", event_valid);
    end
    step();
    checks++;
    if ({event_valid, event_type} !== 3'b1_10) begin
      failures++;
      $display("FAIL grow_long: got v=%b t=%b want v=1 t=10", event_valid, event_type);
    end
    switch_level = 1'b0;
    step();
    long_press_ticks = 16'd10; switch_level = 1'b1;
    repeat (5) step();
    long_press_ticks = 16'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (event_valid !== 1'b0) begin
        failures++;
        $display("FAIL shrink_no_long %0d: got v=%b want 0", i, event_valid);
      end
    end
    switch_level = 1'b0;
    step();
    checks++;
    if ({event_valid, event_type} !== 3'b1_01) begin
      failures++;
      $display("FAIL shrink_short: got v=%b t=%b want v=1 t=01", event_valid, event_type);
    end
    step();
    long_press_ticks = 16'd1; switch_level = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (event_valid !== 1'b0) begin
        failures++;
        $display("FAIL disabled_no_long %0d: got v=%b want 0", i, event_valid);
      end
    end
    switch_level = 1'b0;
    step();
    checks++;
    if ({event_valid, event_type} !== 3'b1_01) begin
      failures++;
      $display("FAIL disabled_short: got v=%b t=%b want v=1 t=01", event_valid, event_type);
    end
    step();
  endtask

  task automatic test_overflow();
    clk_enable = 1'b1; long_press_ticks = 16'd10; repeat_ticks = 16'd0;
    event_ack = 1'b0; overflow_clear = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      switch_level = 1'b1;
      step();
      switch_level = 1'b0;
      step();
      if (p == 2) begin
        checks++;
        if ({event_valid, event_type, event_overflow} !== 4'b1_01_0) begin
          failures++;
          $display("FAIL ovf_two_queued: got v=%b t=%b ovf=%b want v=1 t=01 ovf=0",
                   event_valid, event_type, event_overflow);
        end
      end
    end
    checks++;
    if ({event_valid, event_type, event_overflow} !== 4'b1_01_1) begin
      failures++;
      $display("FAIL ovf_dropped: got v=%b t=%b ovf=%b want v=1 t=01 ovf=1",
               event_valid, event_type, event_overflow);
    end
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    checks++;
    if ({event_valid, event_overflow} !== 2'b10) begin
      failures++;
      $display("FAIL ovf_clear: got v=%b ovf=%b want v=1 ovf=0", event_valid, event_overflow);
    end
    event_ack = 1'b1;
    step();
    checks++;
    if ({event_valid, event_type} !== 3'b1_01) begin
      failures++;
      $display("FAIL ovf_pop1: got v=%b t=%b want v=1 t=01", event_valid, event_type);
    end
    step();
    checks++;
    if (event_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pop2: got v=%b want 0", event_valid);
    end
    event_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    clk_enable = 1'b1; long_press_ticks = 16'd2; repeat_ticks = 16'd0;
    event_ack = 1'b0; overflow_clear = 1'b0;
    switch_level = 1'b1; step();
    switch_level = 1'b0; step();
    switch_level = 1'b1; step();
    step();
    checks++;
    if ({event_valid, event_type, event_overflow} !== 4'b1_01_0) begin
      failures++;
      $display("FAIL b2b_full: got v=%b t=%b ovf=%b want v=1 t=01 ovf=0",
               event_valid, event_type, event_overflow);
    end
    repeat_ticks = 16'd1; event_ack = 1'b1;
    step();
    checks++;
    if ({event_valid, event_type, event_overflow} !== 4'b1_10_0) begin
      failures++;
      $display("FAIL b2b_push_pop: got v=%b t=%b ovf=%b want v=1 t=10 ovf=0",
               event_valid, event_type, event_overflow);
    end
    repeat_ticks = 16'd0;
    step();
    checks++;
    if ({event_valid, event_type} !== 3'b1_11) begin
      failures++;
      $display("FAIL b2b_order: got v=%b t=%b want v=1 t=11", event_valid, event_type);
    end
    step();
    checks++;
    if ({event_valid, event_overflow} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_drained: got v=%b ovf=%b want 0 0", event_valid, event_overflow);
    end
    switch_level = 1'b0; event_ack = 1'b0;
    step();
  endtask

  task automatic test_clk_enable();
    long_press_ticks = 16'd3; repeat_ticks = 16'd0;
    event_ack = 1'b0; switch_level = 1'b1;
    for (int i = 0; i < 9; i++) begin
      clk_enable = (i % 4 == 0);
      step();
      if (i == 0 || i == 7) begin
        checks++;
        if ({pressed, event_valid} !== 2'b10) begin
          failures++;
          $display("FAIL en_wait clk %0d: got p=%b v=%b want p=1 v=0", i, pressed, event_valid);
        end
      end
    end
    checks++;
    if ({event_valid, event_type} !== 3'b1_10) begin
      failures++;
      $display("FAIL en_long: got v=%b t=%b want v=1 t=10", event_valid, event_type);
    end
    clk_enable = 1'b0; event_ack = 1'b1;
    step();
    event_ack = 1'b0;
    checks++;
    if ({event_valid, pressed} !== 2'b01) begin
      failures++;
      $display("FAIL en_ack_no_tick: got v=%b p=%b want v=0 p=1", event_valid, pressed);
    end
    clk_enable = 1'b1; switch_level = 1'b0;
    step();
    checks++;
    if ({event_valid, pressed} !== 2'b00) begin
      failures++;
      $display("FAIL en_release: got v=%b p=%b want 0 0", event_valid, pressed);
    end
  endtask

  task automatic test_reset_mid_press();
    clk_enable = 1'b1; long_press_ticks = 16'd2; repeat_ticks = 16'd1;
    event_ack = 1'b0; switch_level = 1'b1;
    repeat (3) step();
    checks++;
    if ({event_valid, event_type, pressed} !== 4'b1_10_1) begin
      failures++;
      $display("FAIL rst_setup: got v=%b t=%b p=%b want v=1 t=10 p=1",
               event_valid, event_type, pressed);
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if ({event_valid, event_type, event_overflow, pressed} !== 5'b0_00_0_0) begin
      failures++;
      $display("FAIL rst_async: got v=%b t=%b ovf=%b p=%b want all 0",
               event_valid, event_type, event_overflow, pressed);
    end
    #1;
    reset_n = 1'b1;
    clk_enable = 1'b0;
    step();
    checks++;
    if (pressed !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_tick: got p=%b want 0", pressed);
    end
    clk_enable = 1'b1;
    step();
    checks++;
    if ({pressed, event_valid} !== 2'b10) begin
      failures++;
      $display("FAIL rst_new_press: got p=%b v=%b want p=1 v=0", pressed, event_valid);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    clk_enable = 1'b0;
    switch_level = 1'b0;
    long_press_ticks = 16'd10;
    repeat_ticks = 16'd0;
    event_ack = 1'b0;
    overflow_clear = 1'b0;

    test_reset();
    test_short();
    test_long_repeat();
    test_mid_change();
    test_overflow();
    test_back_to_back();
    test_clk_enable();
    test_reset_mid_press();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
